adb_sweep_ctrl: RTL and testbench

Sequencing controller for the 3-input/2-output ADB logic block.
- On `start`, drives all 8 input combinations {a,b,c} = 0..7 onto the ADB block in order.
- After a programmable settle time per vector, captures x and y and compares them against a golden truth table.
- Reports per-vector captures, a failure count and pass/fail; serves as an on-chip self-check beside the ADB datapath.

---
 rtl/adb_sweep_ctrl_if.sv | 36 +++
 rtl/adb_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_adb_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adb_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// adb_sweep_ctrl_if
//   Connection between the sweep controller and the 3-input/2-output ADB
//   logic block.
//
//   Signals:
//     a, b, c : vector bits driven towards the ADB block (a = MSB)
//     x, y    : ADB block results returned to the controller
//
//   Modports:
//     master : controller side (drives a/b/c, observes x/y)
//     slave  : ADB block side  (observes a/b/c, drives x/y)
// ---------------------------------------------------------------------------
interface adb_sweep_ctrl_if;
    logic a;
    logic b;
    logic c;
    logic x;
    logic y;

    modport master (
        output a,
        output b,
        output c,
        input  x,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output x,
        output y
    );
endinterface

// File: rtl/adb_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// adb_sweep_ctrl
//   On-chip self-check sequencer for the ADB logic block. On start it walks
//   {a,b,c} through 0..7, holds each vector for SETTLE_CYCLES cycles, samples
//   x/y for one cycle and compares them with a golden truth table latched at
//   start. Reports per-vector captures, a failure count, the lowest failing
//   vector and an overall pass flag.
//
//   Parameters:
//     SETTLE_CYCLES : hold cycles per vector before sampling (1..15)
//
//   Optional build macro:
//     ADB_SWEEP_STEP_EN : adds input `step`; once a vector's settle time has
//                         elapsed the FSM waits for step=1 before sampling.
//
//   Ports:
//     clk, rst_n       : clock (rising edge), async active-low reset
//     start            : begin a sweep (only honoured in idle)
//     abort            : cancel a running sweep, keeps partial results
//     step             : single-step advance (ADB_SWEEP_STEP_EN only)
//     golden_x/_y      : expected x/y, bit i for vector i
//     adb              : ADB block connection (master modport)
//     busy             : sweep in progress, through the done cycle
//     done             : one-cycle completion pulse
//     pass             : no failing vectors; valid from done to next start
//     fail_count       : number of failing vectors (0..8)
//     first_fail_idx   : lowest failing vector, 0 if none
//     cap_x, cap_y     : captured x/y, bit i for vector i
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module adb_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef ADB_SWEEP_STEP_EN
    input  logic             step,
`endif
    input  logic [7:0]       golden_x,
    input  logic [7:0]       golden_y,
    adb_sweep_ctrl_if.master adb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_count,
    output logic [2:0]       first_fail_idx,
    output logic [7:0]       cap_x,
    output logic [7:0]       cap_y
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("adb_sweep_ctrl: SETTLE_CYCLES must be within 1..15");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  gx_q, gx_d;
    logic [7:0]  gy_q, gy_d;
    logic [2:0]  abc_q, abc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  fail_q, fail_d;
    logic [2:0]  ffi_q, ffi_d;
    logic [7:0]  capx_q, capx_d;
    logic [7:0]  capy_q, capy_d;

    logic        settle_last;
    logic        settle_go;
    logic        vec_fail;

    assign settle_last = (cnt_q == SettleLast);

`ifdef ADB_SWEEP_STEP_EN
    // Settle time must elapse first; then the vector is held until stepped.
    assign settle_go = settle_last & step;
`else
    assign settle_go = settle_last;
`endif

    assign vec_fail = (adb.x != gx_q[idx_q]) || (adb.y != gy_q[idx_q]);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // start beats a simultaneous abort; abort has no meaning here
                if (start) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_go) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (idx_q == 3'd7) begin
                    state_d = StDone;
                end else begin
                    state_d = StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered-output next values
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        gx_d   = gx_q;
        gy_d   = gy_q;
        pass_d = pass_q;
        fail_d = fail_q;
        ffi_d  = ffi_q;
        capx_d = capx_q;
        capy_d = capy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gx_d   = golden_x;
                    gy_d   = golden_y;
                    capx_d = 8'h00;
                    capy_d = 8'h00;
                    fail_d = 4'd0;
                    ffi_d  = 3'd0;
                    pass_d = 1'b0;
                    idx_d  = 3'd0;
                    cnt_d  = 4'd0;
                end
            end
            StSettle: begin
                // Saturate at the last count so a stepped hold stays expired.
                if (!abort && !settle_last) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                // abort suppresses the capture of the vector being sampled
                if (!abort) begin
                    capx_d[idx_q] = adb.x;
                    capy_d[idx_q] = adb.y;
                    if (vec_fail) begin
                        fail_d = fail_q + 4'd1;
                        if (fail_q == 4'd0) begin
                            ffi_d = idx_q;
                        end
                    end
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = 4'd0;
                    end
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase

        // pass is decided on entry to done so it is valid alongside the pulse.
        if (state_d == StDone) begin
            pass_d = (fail_d == 4'd0);
        end

        abc_d  = ((state_d == StSettle) || (state_d == StSample)) ? idx_d : 3'd0;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // -----------------------------------------------------------------------
    // Datapath / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 3'd0;
            cnt_q  <= 4'd0;
            gx_q   <= 8'h00;
            gy_q   <= 8'h00;
            abc_q  <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 4'd0;
            ffi_q  <= 3'd0;
            capx_q <= 8'h00;
            capy_q <= 8'h00;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            abc_q  <= abc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ffi_q  <= ffi_d;
            capx_q <= capx_d;
            capy_q <= capy_d;
        end
    end

    assign adb.a          = abc_q[2];
    assign adb.b          = abc_q[1];
    assign adb.c          = abc_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;
    assign cap_x          = capx_q;
    assign cap_y          = capy_q;

endmodule

// File: tb/tb_adb_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adb_sweep_ctrl
//   Self-checking bench for adb_sweep_ctrl. A behavioural ADB block
//   (x = a^b^c, y = maj(a,b,c), with optional per-vector corruption) sits on
//   the slave side of the interface. Expected results come from a truth-table
//   model evaluated per vector index with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_adb_sweep_ctrl;

    localparam int S   = 2;
    localparam int LAT = 1 + 8 * (S + 1);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
`ifdef ADB_SWEEP_STEP_EN
    logic       step;
`endif
    logic [7:0] golden_x;
    logic [7:0] golden_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_count;
    logic [2:0] first_fail_idx;
    logic [7:0] cap_x;
    logic [7:0] cap_y;

    logic [7:0] flip_x;
    logic [7:0] flip_y;

    int n_checks;
    int n_pass;

    adb_sweep_ctrl_if adb_bus ();

    // Behavioural ADB block, optionally corrupted per vector.
    logic [2:0] vec;
    assign vec       = {adb_bus.a, adb_bus.b, adb_bus.c};
    assign adb_bus.x = (adb_bus.a ^ adb_bus.b ^ adb_bus.c) ^ flip_x[vec];
    assign adb_bus.y = ((adb_bus.a & adb_bus.b) | (adb_bus.a & adb_bus.c) |
                        (adb_bus.b & adb_bus.c)) ^ flip_y[vec];

    adb_sweep_ctrl #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
`ifdef ADB_SWEEP_STEP_EN
        .step           (step),
`endif
        .golden_x       (golden_x),
        .golden_y       (golden_y),
        .adb            (adb_bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .cap_x          (cap_x),
        .cap_y          (cap_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truth-table model: results after the first n_vec vectors were sampled.
    task automatic model(input logic [7:0] gx, input logic [7:0] gy, input int n_vec,
                         output logic [7:0] ex_cx, output logic [7:0] ex_cy,
                         output int ex_fail, output int ex_ffi);
        ex_cx   = 8'h00;
        ex_cy   = 8'h00;
        ex_fail = 0;
        ex_ffi  = 0;
        for (int i = 0; i < n_vec; i++) begin
            ex_cx[i] = (($countones(i) % 2) == 1) ^ flip_x[i];
            ex_cy[i] = ($countones(i) >= 2) ^ flip_y[i];
            if (ex_cx[i] != gx[i] || ex_cy[i] != gy[i]) begin
                if (ex_fail == 0) ex_ffi = i;
                ex_fail++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".abc"},  {29'd0, adb_bus.a, adb_bus.b, adb_bus.c}, 0);
        check({tag, ".busy"}, {31'd0, busy}, 0);
        check({tag, ".done"}, {31'd0, done}, 0);
        check({tag, ".pass"}, {31'd0, pass}, 0);
        check({tag, ".fail"}, {28'd0, fail_count}, 0);
        check({tag, ".ffi"},  {29'd0, first_fail_idx}, 0);
        check({tag, ".capx"}, {24'd0, cap_x}, 0);
        check({tag, ".capy"}, {24'd0, cap_y}, 0);
    endtask

    task automatic check_results(input string tag, input logic [7:0] gx, input logic [7:0] gy,
                                 input int n_vec, input logic ex_pass);
        logic [7:0] ex_cx;
        logic [7:0] ex_cy;
        int         ex_fail;
        int         ex_ffi;
        model(gx, gy, n_vec, ex_cx, ex_cy, ex_fail, ex_ffi);
        check({tag, ".capx"}, {24'd0, cap_x}, {24'd0, ex_cx});
        check({tag, ".capy"}, {24'd0, cap_y}, {24'd0, ex_cy});
        check({tag, ".fail"}, {28'd0, fail_count}, ex_fail);
        check({tag, ".ffi"},  {29'd0, first_fail_idx}, ex_ffi);
        check({tag, ".pass"}, {31'd0, pass}, {31'd0, ex_pass && (ex_fail == 0)});
    endtask

    // One sweep from start pulse to idle. restart/change/abort cycles of -1
    // mean "none"; cycle 1 is the first cycle after the edge that took start.
    task automatic run_sweep(input string tag, input logic [7:0] gx, input logic [7:0] gy,
                             input int restart_cyc, input int change_cyc, input int abort_cyc);
        int         done_cyc;
        int         done_cnt;
        int         abc_err;
        int         busy_err;
        int         last;
        int         n_vec;
        int         exp_abc;
        logic       active;
        done_cyc = -1;
        done_cnt = 0;
        abc_err  = 0;
        busy_err = 0;
        golden_x = gx;
        golden_y = gy;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last = (abort_cyc > 0) ? abort_cyc + 3 : LAT + 2;
        for (int c = 1; c <= last; c++) begin
            active  = (abort_cyc < 0 || c <= abort_cyc) && c <= LAT;
            exp_abc = (active && c < LAT) ? (c - 1) / (S + 1) : 0;
            if ({adb_bus.a, adb_bus.b, adb_bus.c} != 3'(exp_abc)) abc_err++;
            if (busy != active) busy_err++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            start = (c == restart_cyc);
            abort = (c == abort_cyc);
            if (c == change_cyc) begin
                golden_x = 8'($urandom);
                golden_y = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, ".abc_seq"},  abc_err, 0);
        check({tag, ".busy_seq"}, busy_err, 0);
        check({tag, ".done_cnt"}, done_cnt, (abort_cyc > 0) ? 0 : 1);
        check({tag, ".done_cyc"}, done_cyc, (abort_cyc > 0) ? -1 : LAT);
        n_vec = 0;
        for (int i = 0; i < 8; i++) begin
            if (abort_cyc < 0 || (i + 1) * (S + 1) < abort_cyc) n_vec++;
        end
        check_results(tag, gx, gy, n_vec, abort_cyc < 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
`ifdef ADB_SWEEP_STEP_EN
        step     = 1'b1;
`endif
        golden_x = 8'h00;
        golden_y = 8'h00;
        flip_x   = 8'h00;
        flip_y   = 8'h00;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean sweep against the correct truth table.
        run_sweep("clean", 8'h96, 8'hE8, -1, -1, -1);

        // Wrong golden table; golden inputs disturbed mid-sweep.
        run_sweep("bad_gold", 8'h97, 8'h00, -1, 12, -1);

        // start during a running sweep is ignored.
        run_sweep("restart", 8'h96, 8'hE8, 10, -1, -1);

        // abort while vector 3 settles, and in vector 2's sample cycle.
        run_sweep("abort10", 8'h96, 8'hE8, -1, -1, 10);
        run_sweep("abort9", 8'h96, 8'hE8, -1, -1, 9);

        // start and abort together in idle: start wins.
        abort = 1'b1;
        run_sweep("st_ab", 8'h96, 8'hE8, -1, -1, -1);

        // Randomised faulty ADB block and golden tables.
        for (int t = 0; t < 6; t++) begin
            flip_x = 8'($urandom);
            flip_y = 8'($urandom) & 8'($urandom);
            run_sweep("rand", 8'($urandom_range(0, 1) ? 8'h96 : $urandom),
                      8'($urandom_range(0, 1) ? 8'hE8 : $urandom), -1,
                      $urandom_range(1, LAT), -1);
        end
        flip_x = 8'h00;
        flip_y = 8'h00;

        // Reset in the middle of a sweep, then a normal sweep.
        golden_x = 8'h96;
        golden_y = 8'hE8;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check({"post_rst", ".busy"}, {31'd0, busy}, 0);
        run_sweep("after_rst", 8'h96, 8'hE8, -1, -1, -1);

`ifdef ADB_SWEEP_STEP_EN
        begin
            int hold_err;
            int got_done;
            hold_err = 0;
            got_done = 0;
            step = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (12) begin
                if ({adb_bus.a, adb_bus.b, adb_bus.c} != 3'd0 || !busy) hold_err++;
                @(negedge clk);
            end
            check("step.hold", hold_err, 0);
            for (int v = 0; v < 8; v++) begin
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
                if (v < 7) repeat (S + 1) @(negedge clk);
            end
            for (int k = 0; k < 6 && got_done == 0; k++) begin
                @(negedge clk);
                if (done) got_done = 1;
            end
            check("step.done", got_done, 1);
            check_results("step", 8'h96, 8'hE8, 8, 1'b1);
            step = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
